// File: rtl/pixel_packer_pkg.sv
// Shared types and helpers for the serial-beat to parallel-pixel packer.
// slot_lsb maps a beat index to its bit offset inside the packed pixel word.
package pixel_packer_pkg;

    localparam int ERR_CNT_W = 16;

    function automatic int slot_lsb(input int k, input int ch_num, input int data_w,
                                    input bit msb_first);
        return msb_first ? (ch_num - 1 - k) * data_w : k * data_w;
    endfunction

endpackage

// File: rtl/pixel_out_reg.sv
// Ready/valid pixel holding register; loads a packed pixel and holds it until accepted.
// Latency: one register stage from load to m_valid.
// Backpressure: data held stable while !m_ready; a load in the handshake cycle keeps m_valid high.
module pixel_out_reg #(
    parameter int PIX_W = 24
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             load,
    input  logic [PIX_W-1:0] load_data,
    input  logic             load_sof,
    input  logic             m_ready,
    output logic             m_valid,
    output logic [PIX_W-1:0] m_data,
    output logic             m_sof
);

    logic             m_valid_q, m_valid_d;
    logic [PIX_W-1:0] m_data_q, m_data_d;
    logic             m_sof_q, m_sof_d;

    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_sof_d   = m_sof_q;
        if (load) begin
            m_valid_d = 1'b1;
            m_data_d  = load_data;
            m_sof_d   = load_sof;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_sof_q   <= 1'b0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_sof_q   <= m_sof_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_sof   = m_sof_q;

endmodule

// File: rtl/pixel_packer.sv
// Packs CH_NUM serial DATA_W beats into one pixel word, with SOF realignment and error count.
// Latency: final beat accepted at edge N gives m_valid after edge N.
// Backpressure: only the final beat of a pixel stalls; s_ready is combinational from m_ready.
module pixel_packer
    import pixel_packer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CH_NUM    = 3,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_sof,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [CH_NUM*DATA_W-1:0] m_data,
    output logic                     m_sof,
    output logic                     err_align,
    output logic [ERR_CNT_W-1:0]     err_cnt
);

    localparam int PIX_W  = CH_NUM * DATA_W;
    localparam int HOLD_W = (CH_NUM - 1) * DATA_W;
    localparam int CNT_W  = $clog2(CH_NUM);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CH_NUM - 1);

    logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 sof0_q, sof0_d;
    logic                 err_align_q, err_align_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             is_last;
    logic             accept;
    logic             realign;
    logic             load;
    logic [PIX_W-1:0] pix;

    assign is_last = (beat_cnt_q == LAST_BEAT);
    assign s_ready = !is_last || !m_valid || m_ready;
    assign accept  = s_valid && s_ready;
    // A realigning SOF wins over the final-beat load, even when it lands in the last slot.
    assign realign = accept && s_sof && (beat_cnt_q != '0);
    assign load    = accept && is_last && !realign;

    // Oldest held beat sits at the top of hold_q; beat k lives at index CH_NUM-2-k.
    always_comb begin
        pix = '0;
        for (int k = 0; k < CH_NUM - 1; k++) begin
            pix[slot_lsb(k, CH_NUM, DATA_W, MSB_FIRST) +: DATA_W] =
                hold_q[(CH_NUM - 2 - k) * DATA_W +: DATA_W];
        end
        pix[slot_lsb(CH_NUM - 1, CH_NUM, DATA_W, MSB_FIRST) +: DATA_W] = s_data;
    end

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        hold_d      = hold_q;
        sof0_d      = sof0_q;
        err_align_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (realign) begin
            beat_cnt_d  = CNT_W'(1);
            hold_d      = HOLD_W'(s_data);
            sof0_d      = 1'b1;
            err_align_d = 1'b1;
            if (err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end else if (load) begin
            beat_cnt_d = '0;
            hold_d     = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            hold_d     = (hold_q << DATA_W) | HOLD_W'(s_data);
            if (beat_cnt_q == '0) begin
                sof0_d = s_sof;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            beat_cnt_q  <= '0;
            hold_q      <= '0;
            sof0_q      <= 1'b0;
            err_align_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            hold_q      <= hold_d;
            sof0_q      <= sof0_d;
            err_align_q <= err_align_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    pixel_out_reg #(
        .PIX_W(PIX_W)
    ) u_out_reg (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (load),
        .load_data (pix),
        .load_sof  (sof0_q),
        .m_ready   (m_ready),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_sof     (m_sof)
    );

    assign err_align = err_align_q;
    assign err_cnt   = err_cnt_q;

endmodule
